// File: rtl/sha_msg_loader.sv
// sha_msg_loader: reads a message from BRAM, applies SHA padding and streams 32-bit words to the hash core
module sha_msg_loader #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  input  logic [ADDR_W-1:0] encrypt_data_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [31:0]       mem_data,
  output logic [31:0]       word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              block_last,
  output logic              msg_last,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] w_q, w_d, w_nx;
  logic [LEN_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d, mem_addr_q, mem_addr_d;
  logic [31:0] word_q, word_d;
  logic last;
  function automatic logic [7:0] last_idx(input logic [LEN_W-1:0] l);
    return 8'((((32'(l) + 32'd8) >> 6) << 4) + 32'd15);
  endfunction
  // memory is needed for every word holding at least one message byte
  function automatic logic needs_read(input logic [7:0] w, input logic [LEN_W-1:0] l);
    return 32'(w) < ((32'(l) + 32'd3) >> 2);
  endfunction
  function automatic logic [31:0] pad(input logic [7:0] w, input logic [LEN_W-1:0] l);
    return w == last_idx(l) ? 32'(l) << 3 :
           (32'(w) == (32'(l) >> 2) && l[1:0] == 2'd0) ? 32'h8000_0000 : 32'h0;
  endfunction
  function automatic logic [31:0] masked(input logic [31:0] d, input logic [7:0] w, input logic [LEN_W-1:0] l);
    return 32'(w) != (32'(l) >> 2) ? d :
           l[1:0] == 2'd1 ? {d[31:24], 24'h80_0000} :
           l[1:0] == 2'd2 ? {d[31:16], 16'h8000} : {d[31:8], 8'h80};
  endfunction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      w_q        <= '0;
      len_q      <= '0;
      base_q     <= '0;
      mem_addr_q <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      len_q      <= len_d;
      base_q     <= base_d;
      mem_addr_q <= mem_addr_d;
      word_q     <= word_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    len_d      = len_q;
    base_d     = base_q;
    mem_addr_d = mem_addr_q;
    word_d     = word_q;
    w_nx       = w_q + 8'd1;
    last       = w_q == last_idx(len_q);
    unique case (state_q)
      IDLE: if (start) begin
        len_d      = length;
        base_d     = encrypt_data_addr;
        mem_addr_d = encrypt_data_addr;
        w_d        = '0;
        state_d    = length != '0 ? FETCH : SEND;
        word_d     = length != '0 ? word_q : pad(8'd0, length);
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        word_d  = masked(mem_data, w_q, len_q);
        state_d = SEND;
      end
      SEND: if (word_ready) begin
        if (last) state_d = DONE;
        else begin
          w_d = w_nx;
          if (needs_read(w_nx, len_q)) begin
            state_d    = FETCH;
            mem_addr_d = base_q + ADDR_W'(w_nx);
          end else word_d = pad(w_nx, len_q);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    mem_addr   = mem_addr_q;
    mem_en     = state_q == FETCH;
    word_out   = word_q;
    word_valid = state_q == SEND;
    block_last = word_valid && (&w_q[3:0]);
    msg_last   = word_valid && last;
    busy       = state_q inside {FETCH, LOAD, SEND};
    done       = state_q == DONE;
  end
endmodule

// File: tb/tb_sha_msg_loader.sv
// tb_sha_msg_loader: directed and randomized checks of padded message streaming against a byte-level model
module tb_sha_msg_loader;
  logic        clk = 0;
  logic        reset = 1;
  logic        start = 0;
  logic [8:0]  length = '0;
  logic [9:0]  encrypt_data_addr = '0;
  logic [9:0]  mem_addr;
  logic        mem_en;
  logic [31:0] mem_data = '0;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready = 1;
  logic        block_last;
  logic        msg_last;
  logic        busy;
  logic        done;
  logic [31:0] mem [1024];
  int checks = 0;
  int fails = 0;

  sha_msg_loader dut (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .encrypt_data_addr(encrypt_data_addr), .mem_addr(mem_addr), .mem_en(mem_en),
    .mem_data(mem_data), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready), .block_last(block_last), .msg_last(msg_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_en) mem_data <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // padded message viewed as a flat byte string: data, 0x80, zeros, 64-bit bit length
  function automatic logic [31:0] model_word(input int l, input int base, input int w);
    logic [31:0] r = '0;
    logic [63:0] bits = 64'(l) * 64'd8;
    int nbytes = ((l + 8) / 64 + 1) * 64;
    for (int j = 0; j < 4; j++) begin
      int i = 4 * w + j;
      logic [7:0] b;
      logic [31:0] mw = mem[(base + i / 4) % 1024];
      if (i < l) b = mw[31 - 8 * (i % 4) -: 8];
      else if (i == l) b = 8'h80;
      else if (i >= nbytes - 8) b = bits[63 - 8 * (i - (nbytes - 8)) -: 8];
      else b = 8'h00;
      r[31 - 8 * j -: 8] = b;
    end
    return r;
  endfunction

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_outs"}, {24'b0, mem_en, word_valid, block_last, msg_last, busy, done, 2'b0}, 0);
    chk({tag, "_word"}, word_out, 0);
  endtask

  task automatic run_msg(input int l, input int base, input bit stall, input int abort_at, input bit poke);
    int idx = 0, reads = 0, cyc = 0;
    int nw = ((l + 8) / 64 + 1) * 16;
    bit prev_stall = 0, first = 1, fin = 0, poked = 0;
    logic [31:0] held = '0;
    @(negedge clk);
    length = 9'(l); encrypt_data_addr = 10'(base); start = 1; word_ready = 1;
    @(negedge clk);
    start = 0;
    while (!fin && cyc < 5000) begin
      if (mem_en) reads++;
      if (busy !== 1'b1) chk("busy_during", 32'(busy), 1);
      if (word_valid && first) begin
        chk("first_latency", cyc, l == 0 ? 0 : 2);
        first = 0;
      end
      if (word_valid && idx == abort_at) begin
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk_idle_zero("abort");
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("abort_no_done", 32'(done | busy | word_valid), 0);
        end
        return;
      end
      if (word_valid && prev_stall) chk("stall_hold", word_out, held);
      word_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      start = poke && idx == 3 && !poked;
      if (start) begin
        poked = 1;
        length = 9'($urandom);
        encrypt_data_addr = 10'($urandom);
      end
      if (word_valid && word_ready) begin
        chk($sformatf("word%0d_L%0d", idx, l), word_out, model_word(l, base, idx));
        chk($sformatf("blast%0d", idx), 32'(block_last), 32'(idx % 16 == 15));
        chk($sformatf("mlast%0d", idx), 32'(msg_last), 32'(idx == nw - 1));
        idx++;
        if (idx == nw) fin = 1;
      end
      prev_stall = word_valid && !word_ready;
      held = word_out;
      @(negedge clk);
      start = 0;
      cyc++;
    end
    chk("stream_complete", 32'(fin), 1);
    chk("done_pulse", 32'(done), 1);
    chk("busy_at_done", 32'(busy), 0);
    chk("read_count", reads, (l + 3) / 4);
    @(negedge clk);
    chk("done_clear", 32'(done), 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[16] = 32'h616263FF;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    reset = 0;
    run_msg(0, 'h000, 0, -1, 0);
    run_msg(3, 'h010, 0, -1, 0);
    chk("L3_word0", model_word(3, 'h010, 0), 32'h61626380);
    run_msg(56, 'h020, 0, -1, 0);
    run_msg(511, 'h3FE, 0, -1, 0);
    run_msg(8, 'h100, 1, -1, 0);
    run_msg(20, 'h040, 0, 5, 0);
    run_msg(20, 'h040, 0, -1, 1);
    for (int t = 0; t < 6; t++)
      run_msg(int'($urandom_range(0, 511)), int'($urandom_range(0, 1023)), 1, -1, t[0]);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
